// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first,
// carry rippled through a register; done pulses for one cycle with the result.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             err_pend_q, err_pend_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic             bad_nibble;
    logic [5:0]       raw;
    logic [3:0]       digit;
    logic             carry_nxt;
    logic [W-1:0]     work_shift;

    always_comb begin
        bad_nibble = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                bad_nibble = 1'b1;
            end
        end
    end

    // Operands shift right each step, so the active digit is always nibble 0;
    // the result shifts in from the top and lands in place after DIGITS steps.
    always_comb begin
        raw        = {2'b00, op_a_q[3:0]} + {2'b00, op_b_q[3:0]} + {5'b00000, carry_q};
        carry_nxt  = (raw > 6'd9);
        digit      = carry_nxt ? (raw[3:0] + 4'd6) : raw[3:0];
        work_shift = (work_q >> 4) | (W'(digit) << (W - 4));
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        work_d     = work_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        err_pend_d = err_pend_q;
        cout_d     = cout_q;
        err_d      = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_a_d     = a;
                    op_b_d     = b;
                    carry_d    = cin;
                    idx_d      = '0;
                    work_d     = '0;
                    err_pend_d = bad_nibble;
                    state_d    = ADD;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                op_a_d  = op_a_q >> 4;
                op_b_d  = op_b_q >> 4;
                carry_d = carry_nxt;
                work_d  = work_shift;
                if (idx_q == LAST_IDX) begin
                    sum_d   = work_shift;
                    cout_d  = carry_nxt;
                    err_d   = err_pend_q;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            work_q     <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            err_pend_q <= 1'b0;
            cout_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            work_q     <= work_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            err_pend_q <= err_pend_d;
            cout_q     <= cout_d;
            err_q      <= err_d;
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed + scoreboard bench for bcd_serial_adder_ctrl (DIGITS=4).
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int           errors   = 0;
    int           checks   = 0;
    int           done_cnt = 0;
    logic [W-1:0] last_sum = '0;
    exp_t         sb[$];

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t bcd_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t r;
        int   xd, yd, raw;
        logic cy;
        r  = '0;
        cy = c;
        for (int d = 0; d < DIGITS; d++) begin
            xd = int'(x[d*4 +: 4]);
            yd = int'(y[d*4 +: 4]);
            if (xd > 9 || yd > 9) r.err = 1'b1;
            raw = xd + yd + int'(cy);
            if (raw > 9) begin
                r.sum[d*4 +: 4] = 4'(raw + 6);
                cy = 1'b1;
            end else begin
                r.sum[d*4 +: 4] = 4'(raw);
                cy = 1'b0;
            end
        end
        r.cout = cy;
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            check("busy_low_at_done", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_done: observed=done expected=no_done");
            end else begin
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    // One complete transaction with busy/done timing and output-hold checks;
    // inputs are scrambled during ADD to show they are not resampled.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic [W-1:0] es, input logic ec, input logic ee);
        exp_t e;
        e.sum = es; e.cout = ec; e.err = ee;
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int i = 0; i < DIGITS; i++) begin
            check("busy_during_add", 32'(busy), 32'd1);
            check("sum_hold_during_add", 32'(sum), 32'(last_sum));
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        last_sum = es;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        exp_t         m;
        exp_t         e;
        int           cnt0;
        logic [W-1:0] ra, rb;
        logic         rc;

        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

        // Mid-clock reset with non-zero outputs held: clears without an edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_sum = '0;

        // start held high across two runs; second operands presented during ADD.
        cnt0 = done_cnt;
        @(negedge clk);
        a = 16'h0456; b = 16'h0789; cin = 1'b1; start = 1'b1;
        e.sum = 16'h1246; e.cout = 1'b0; e.err = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        a = 16'h5000; b = 16'h5000; cin = 1'b0;
        e.sum = 16'h0000; e.cout = 1'b1; e.err = 1'b0;
        sb.push_back(e);
        check("hold_busy", 32'(busy), 32'd1);
        repeat (DIGITS) @(negedge clk);
        check("hold_done1", 32'(done), 32'd1);
        @(negedge clk);
        check("hold_rebusy", 32'(busy), 32'd1);
        check("hold_sum_kept", 32'(sum), 32'h1246);
        repeat (DIGITS) @(negedge clk);
        check("hold_done2", 32'(done), 32'd1);
        start = 1'b0;
        @(negedge clk);
        check("hold_idle", 32'(busy | done), 32'd0);
        check("hold_done_count", 32'(done_cnt - cnt0), 32'd2);
        last_sum = 16'h0000;

        run_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        run_op(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Reset two cycles into an operation: result lost, no done pulse.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cnt0 = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (DIGITS + 2) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - cnt0), 32'd0);
        check("abort_sum_stays", 32'(sum), 32'd0);
        last_sum = '0;

        run_op(16'h4321, 16'h1111, 1'b1, 16'h5433, 1'b0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            for (int d = 0; d < DIGITS; d++) begin
                ra[d*4 +: 4] = 4'($urandom_range(0, 9));
                rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom);
            m = bcd_model(ra, rb, rc);
            run_op(ra, rb, rc, m.sum, m.cout, m.err);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
